grain_keystream_ctrl: RTL

Sequencer for the Grain keystream generator. It loads the 80-bit LFSR seed and the 24-bit NFSR seed, clocks a discard warm-up phase, and then packs keystream bits MSB-first into bytes on a valid/ready stream for a fixed byte count per session. It sits between the session-level user and the Grain core, and owns all Grain `Par_load`/`shift_en` sequencing.

---
 rtl/grain_keystream_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/grain_keystream_ctrl.sv
// Grain keystream sequencer: seed load, warm-up discard, MSB-first byte packing on a valid/ready stream.
// Optional bit/pair statistics counters are built only when GRAIN_KS_STATS_EN is defined.
module grain_keystream_ctrl #(
   parameter int WARMUP = 160
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        start,
   input  logic [79:0] seed_l,
   input  logic [23:0] seed_n,
   input  logic [7:0]  len,
   output logic        g_par_load,
   output logic        g_shift_en,
   output logic [79:0] g_seed_l,
   output logic [23:0] g_seed_n,
   input  logic        g_bit,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
`ifdef GRAIN_KS_STATS_EN
   ,
   output logic [15:0] stat_cnt0,
   output logic [15:0] stat_cnt1,
   output logic [15:0] stat_cnt00,
   output logic [15:0] stat_cnt01,
   output logic [15:0] stat_cnt10,
   output logic [15:0] stat_cnt11
`endif
);

   localparam int         DATA_W    = 8;
   localparam logic [9:0] WARM_LAST = 10'(WARMUP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WARM,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [9:0]          r_warm_cnt;
   logic [2:0]          r_bit_cnt;
   logic [DATA_W-2:0]   r_sr;
   logic [7:0]          r_len;
   logic [7:0]          r_byte_cnt;
   logic                r_par_load;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_data;
   logic [79:0]         r_seed_l;
   logic [23:0]         r_seed_n;

   logic w_accept;
   logic w_hs;
   logic w_stall;
   logic w_cap;
   logic w_byte_done;
   logic w_last_byte;

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_hs        = r_valid && out_ready;
   // Bit 7 may only be captured once the output slot is free (or frees on this very edge).
   assign w_stall     = (r_state == S_RUN) && (r_bit_cnt == 3'd7) && r_valid && !out_ready;
   assign w_cap       = (r_state == S_RUN) && !w_stall;
   assign w_byte_done = w_cap && (r_bit_cnt == 3'd7);
   assign w_last_byte = ((r_byte_cnt + 8'd1) == r_len);

   assign g_par_load = r_par_load;
   assign g_shift_en = (r_state == S_WARM) || w_cap;
   assign g_seed_l   = r_seed_l;
   assign g_seed_n   = r_seed_n;
   assign out_data   = r_data;
   assign out_valid  = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_warm_cnt <= '0;
         r_bit_cnt  <= '0;
         r_sr       <= '0;
         r_len      <= '0;
         r_byte_cnt <= '0;
         r_par_load <= 1'b0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_data     <= '0;
         r_seed_l   <= '0;
         r_seed_n   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_seed_l   <= seed_l;
                  r_seed_n   <= seed_n;
                  r_len      <= len;
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_warm_cnt <= '0;
                  r_par_load <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_par_load <= 1'b0;
               r_state    <= S_WARM;
            end
            S_WARM: begin
               if (r_warm_cnt == WARM_LAST) begin
                  if (r_len == 8'd0) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_RUN;
                  end
               end else begin
                  r_warm_cnt <= r_warm_cnt + 10'd1;
               end
            end
            S_RUN: begin
               if (w_cap) begin
                  r_sr      <= {r_sr[DATA_W-3:0], g_bit};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               // A new byte overwrites the slot even when the old one is accepted on this edge.
               if (w_byte_done) begin
                  r_data     <= {r_sr, g_bit};
                  r_valid    <= 1'b1;
                  r_byte_cnt <= r_byte_cnt + 8'd1;
                  if (w_last_byte) begin
                     r_state <= S_DRAIN;
                  end
               end else if (w_hs) begin
                  r_valid <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (w_hs) begin
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef GRAIN_KS_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;
   logic [15:0] r_cnt00;
   logic [15:0] r_cnt01;
   logic [15:0] r_cnt10;
   logic [15:0] r_cnt11;
   logic        r_prev;
   logic        r_have_prev;

   always_ff @(posedge Clk) begin
      if (reset || w_accept) begin
         r_cnt0      <= '0;
         r_cnt1      <= '0;
         r_cnt00     <= '0;
         r_cnt01     <= '0;
         r_cnt10     <= '0;
         r_cnt11     <= '0;
         r_prev      <= 1'b0;
         r_have_prev <= 1'b0;
      end else if (w_cap) begin
         if (g_bit) r_cnt1 <= sat_inc(r_cnt1);
         else       r_cnt0 <= sat_inc(r_cnt0);
         // The first capture of a session has no predecessor and forms no pair.
         if (r_have_prev) begin
            case ({r_prev, g_bit})
               2'b00:   r_cnt00 <= sat_inc(r_cnt00);
               2'b01:   r_cnt01 <= sat_inc(r_cnt01);
               2'b10:   r_cnt10 <= sat_inc(r_cnt10);
               default: r_cnt11 <= sat_inc(r_cnt11);
            endcase
         end
         r_prev      <= g_bit;
         r_have_prev <= 1'b1;
      end
   end

   assign stat_cnt0  = r_cnt0;
   assign stat_cnt1  = r_cnt1;
   assign stat_cnt00 = r_cnt00;
   assign stat_cnt01 = r_cnt01;
   assign stat_cnt10 = r_cnt10;
   assign stat_cnt11 = r_cnt11;
`endif

endmodule
